// File: rtl/arith_rs_wakeup_pkg.sv
// Shared types and sizes for the arithmetic reservation station.
// The entry layout is used by both the storage array and the issue view.
package arith_rs_wakeup_pkg;

    localparam int RS_DEPTH  = 8;
    localparam int PREG_W    = 6;
    localparam int ROB_W     = 5;
    localparam int PAYLOAD_W = 64;

    typedef struct packed {
        logic                 valid;
        logic [PREG_W-1:0]    ps1;
        logic                 r1;
        logic [PREG_W-1:0]    ps2;
        logic                 r2;
        logic [PREG_W-1:0]    pd;
        logic [ROB_W-1:0]     rob;
        logic [PAYLOAD_W-1:0] payload;
    } rs_entry_t;

    // p0 is hard-wired ready; a broadcast in the dispatch cycle must not be lost.
    function automatic logic src_ready(input logic [PREG_W-1:0] ps,
                                       input logic              busy_rdy,
                                       input logic              hit,
                                       input logic [PREG_W-1:0] cdb_pd);
        return busy_rdy | (ps == '0) | (hit & (ps == cdb_pd));
    endfunction

endpackage

// File: rtl/arith_rs_wakeup_if.sv
// Dispatch, CDB snoop and FU issue bundle for the arithmetic reservation station.
// slave = the reservation station, master = the surrounding pipeline.
interface arith_rs_wakeup_if;
    import arith_rs_wakeup_pkg::*;

    logic                 flush;
    logic                 disp_valid;
    logic                 disp_ready;
    logic [PREG_W-1:0]    disp_ps1;
    logic [PREG_W-1:0]    disp_ps2;
    logic                 disp_ps1_rdy;
    logic                 disp_ps2_rdy;
    logic [PREG_W-1:0]    disp_pd;
    logic [ROB_W-1:0]     disp_rob;
    logic [PAYLOAD_W-1:0] disp_payload;
    logic                 cdb_valid;
    logic                 cdb_regf_we;
    logic [PREG_W-1:0]    cdb_pd;
    logic                 iss_valid;
    logic                 iss_ready;
    logic [PREG_W-1:0]    iss_ps1;
    logic [PREG_W-1:0]    iss_ps2;
    logic [PREG_W-1:0]    iss_pd;
    logic [ROB_W-1:0]     iss_rob;
    logic [PAYLOAD_W-1:0] iss_payload;

    modport slave (
        input  flush, disp_valid, disp_ps1, disp_ps2, disp_ps1_rdy, disp_ps2_rdy,
               disp_pd, disp_rob, disp_payload, cdb_valid, cdb_regf_we, cdb_pd, iss_ready,
        output disp_ready, iss_valid, iss_ps1, iss_ps2, iss_pd, iss_rob, iss_payload
    );

    modport master (
        output flush, disp_valid, disp_ps1, disp_ps2, disp_ps1_rdy, disp_ps2_rdy,
               disp_pd, disp_rob, disp_payload, cdb_valid, cdb_regf_we, cdb_pd, iss_ready,
        input  disp_ready, iss_valid, iss_ps1, iss_ps2, iss_pd, iss_rob, iss_payload
    );

endinterface

// File: rtl/arith_rs_wakeup_age_select.sv
// Oldest-ready picker: grants the eligible entry that has no eligible entry older than it.
// Purely combinational; older[i][j]=1 means entry j is older than entry i.
module arith_rs_wakeup_age_select #(
    parameter int DEPTH = 8
) (
    input  logic [DEPTH-1:0]            eligible,
    input  logic [DEPTH-1:0][DEPTH-1:0] older,
    output logic [DEPTH-1:0]            grant,
    output logic                        any
);

    always_comb begin
        grant = '0;
        for (int i = 0; i < DEPTH; i++) begin
            grant[i] = eligible[i] & ~|(eligible & older[i]);
        end
    end

    assign any = |eligible;

endmodule

// File: rtl/arith_rs_wakeup.sv
// Arithmetic reservation station: holds renamed ALU ops, wakes sources from the CDB,
// and issues the oldest fully-ready entry to the ALU under valid/ready.
module arith_rs_wakeup
    import arith_rs_wakeup_pkg::*;
#(
    parameter int DEPTH = RS_DEPTH
) (
    input  logic               clk,
    input  logic               rst,
    arith_rs_wakeup_if.slave   bus
);

    localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    rs_entry_t                   ent [DEPTH];
    logic [DEPTH-1:0][DEPTH-1:0] older;
    logic [DEPTH-1:0]            vld;
    logic [DEPTH-1:0]            elig;
    logic [DEPTH-1:0]            grant;
    logic                        any_elig;
    logic                        hit;
    logic                        has_free;
    logic [IDX_W-1:0]            free_idx;
    logic                        do_disp;
    logic                        do_iss;
    rs_entry_t                   sel;

    always_comb begin
        vld  = '0;
        elig = '0;
        for (int i = 0; i < DEPTH; i++) begin
            vld[i]  = ent[i].valid;
            elig[i] = ent[i].valid & ent[i].r1 & ent[i].r2;
        end
    end

    assign hit = bus.cdb_valid & bus.cdb_regf_we & (bus.cdb_pd != '0);

    // Lowest free slot; derived from registered valids only, so a same-cycle free is not reused.
    always_comb begin
        free_idx = '0;
        has_free = 1'b0;
        for (int i = DEPTH - 1; i >= 0; i--) begin
            if (!vld[i]) begin
                free_idx = IDX_W'(i);
                has_free = 1'b1;
            end
        end
    end

    assign bus.disp_ready = has_free;
    assign do_disp        = bus.disp_valid & has_free & ~bus.flush;

    arith_rs_wakeup_age_select #(.DEPTH(DEPTH)) u_age_select (
        .eligible (elig),
        .older    (older),
        .grant    (grant),
        .any      (any_elig)
    );

    assign bus.iss_valid = any_elig & ~bus.flush;
    assign do_iss        = bus.iss_valid & bus.iss_ready;

    always_comb begin
        sel = '0;
        for (int i = 0; i < DEPTH; i++) begin
            if (grant[i] && bus.iss_valid) sel = ent[i];
        end
    end

    assign bus.iss_ps1     = sel.ps1;
    assign bus.iss_ps2     = sel.ps2;
    assign bus.iss_pd      = sel.pd;
    assign bus.iss_rob     = sel.rob;
    assign bus.iss_payload = sel.payload;

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
            older <= '0;
        end else if (bus.flush) begin
            for (int i = 0; i < DEPTH; i++) ent[i].valid <= 1'b0;
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (do_iss && grant[i]) ent[i].valid <= 1'b0;
                if (hit && ent[i].ps1 == bus.cdb_pd) ent[i].r1 <= 1'b1;
                if (hit && ent[i].ps2 == bus.cdb_pd) ent[i].r2 <= 1'b1;
            end
            // New entry is younger than everything currently valid.
            if (do_disp) begin
                ent[free_idx] <= '{valid:   1'b1,
                                   ps1:     bus.disp_ps1,
                                   r1:      src_ready(bus.disp_ps1, bus.disp_ps1_rdy, hit, bus.cdb_pd),
                                   ps2:     bus.disp_ps2,
                                   r2:      src_ready(bus.disp_ps2, bus.disp_ps2_rdy, hit, bus.cdb_pd),
                                   pd:      bus.disp_pd,
                                   rob:     bus.disp_rob,
                                   payload: bus.disp_payload};
                for (int j = 0; j < DEPTH; j++) begin
                    older[free_idx][j] <= (j != int'(free_idx)) ? vld[j] : 1'b0;
                    older[j][free_idx] <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_arith_rs_wakeup.sv
// Self-checking bench: directed scenarios then random traffic, each cycle compared
// against an age-ordered queue model of the reservation station.
module tb_arith_rs_wakeup;
    import arith_rs_wakeup_pkg::*;

    typedef struct packed {
        logic [PREG_W-1:0]    ps1;
        logic                 r1;
        logic [PREG_W-1:0]    ps2;
        logic                 r2;
        logic [PREG_W-1:0]    pd;
        logic [ROB_W-1:0]     rob;
        logic [PAYLOAD_W-1:0] payload;
    } mdl_ent_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_chk = 0;
    int   n_err = 0;
    mdl_ent_t q[$];

    arith_rs_wakeup_if bus();

    arith_rs_wakeup dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic idle();
        bus.flush        = 1'b0;
        bus.disp_valid   = 1'b0;
        bus.disp_ps1     = '0;
        bus.disp_ps2     = '0;
        bus.disp_ps1_rdy = 1'b0;
        bus.disp_ps2_rdy = 1'b0;
        bus.disp_pd      = '0;
        bus.disp_rob     = '0;
        bus.disp_payload = '0;
        bus.cdb_valid    = 1'b0;
        bus.cdb_regf_we  = 1'b0;
        bus.cdb_pd       = '0;
    endtask

    task automatic disp(input int ps1, input bit r1, input int ps2, input bit r2,
                        input int pd, input int rob);
        bus.disp_valid   = 1'b1;
        bus.disp_ps1     = PREG_W'(ps1);
        bus.disp_ps1_rdy = r1;
        bus.disp_ps2     = PREG_W'(ps2);
        bus.disp_ps2_rdy = r2;
        bus.disp_pd      = PREG_W'(pd);
        bus.disp_rob     = ROB_W'(rob);
        bus.disp_payload = {$urandom, $urandom};
    endtask

    task automatic cdb(input bit we, input int pd);
        bus.cdb_valid   = 1'b1;
        bus.cdb_regf_we = we;
        bus.cdb_pd      = PREG_W'(pd);
    endtask

    // Called with inputs set after a falling edge; checks outputs, advances the model, waits a cycle.
    task automatic step();
        mdl_ent_t e;
        mdl_ent_t n;
        int       idx;
        logic     exp_rdy, exp_iv, hit;
        #1;
        exp_rdy = (q.size() < RS_DEPTH);
        idx = -1;
        for (int i = 0; i < q.size(); i++) begin
            if (idx < 0 && q[i].r1 && q[i].r2) idx = i;
        end
        exp_iv = (idx >= 0) && !bus.flush;
        if (!rst) begin
            e = exp_iv ? q[idx] : '0;
            chk("disp_ready",  bus.disp_ready,  exp_rdy);
            chk("iss_valid",   bus.iss_valid,   exp_iv);
            chk("iss_pd",      bus.iss_pd,      e.pd);
            chk("iss_ps1",     bus.iss_ps1,     e.ps1);
            chk("iss_ps2",     bus.iss_ps2,     e.ps2);
            chk("iss_rob",     bus.iss_rob,     e.rob);
            chk("iss_payload", bus.iss_payload, e.payload);
        end
        hit = bus.cdb_valid && bus.cdb_regf_we && (bus.cdb_pd != 0);
        if (rst || bus.flush) begin
            q.delete();
        end else begin
            if (exp_iv && bus.iss_ready) q.delete(idx);
            for (int i = 0; i < q.size(); i++) begin
                if (hit && q[i].ps1 == bus.cdb_pd) q[i].r1 = 1'b1;
                if (hit && q[i].ps2 == bus.cdb_pd) q[i].r2 = 1'b1;
            end
            if (bus.disp_valid && exp_rdy) begin
                n.ps1     = bus.disp_ps1;
                n.ps2     = bus.disp_ps2;
                n.r1      = bus.disp_ps1_rdy || bus.disp_ps1 == 0 || (hit && bus.disp_ps1 == bus.cdb_pd);
                n.r2      = bus.disp_ps2_rdy || bus.disp_ps2 == 0 || (hit && bus.disp_ps2 == bus.cdb_pd);
                n.pd      = bus.disp_pd;
                n.rob     = bus.disp_rob;
                n.payload = bus.disp_payload;
                q.push_back(n);
            end
        end
        @(negedge clk);
    endtask

    initial begin
        idle();
        bus.iss_ready = 1'b0;
        @(negedge clk);
        repeat (3) step();
        rst = 1'b0;
        repeat (10) step();

        // Late wakeup of one source
        bus.iss_ready = 1'b1;
        disp(5, 0, 0, 0, 9, 1); step();
        idle(); step();
        cdb(1, 5); step();
        idle(); repeat (3) step();

        // Broadcast in the dispatch cycle, with and without a register-file write
        disp(7, 0, 3, 1, 12, 2); cdb(1, 7); step();
        idle(); repeat (2) step();
        disp(7, 0, 3, 1, 13, 3); cdb(0, 7); step();
        idle(); repeat (4) step();
        bus.flush = 1'b1; step();
        idle();

        // Held issue keeps the oldest selected, then drains in age order
        bus.iss_ready = 1'b0;
        disp(1, 1, 2, 1, 20, 4); step();
        disp(3, 1, 0, 0, 21, 5); step();
        disp(0, 0, 4, 1, 22, 6); step();
        idle(); repeat (3) step();
        bus.iss_ready = 1'b1; repeat (4) step();

        // Fill to capacity, drop a ninth dispatch, then free one slot
        bus.flush = 1'b1; step();
        idle();
        for (int i = 0; i < RS_DEPTH; i++) begin
            disp(10 + i, 0, 0, 0, 20 + i, i); step();
        end
        chk("full_ready", bus.disp_ready, 1'b0);
        disp(30, 1, 0, 0, 31, 9); step();
        idle(); cdb(1, 10); step();
        idle(); repeat (3) step();

        // Flush beats a same-cycle dispatch and wakeup
        bus.flush = 1'b1; step();
        idle();
        for (int i = 0; i < 5; i++) begin
            disp(40 + i, 0, 0, 0, 50 + i, i); step();
        end
        idle(); bus.flush = 1'b1; disp(1, 1, 2, 1, 60, 15); cdb(1, 40); step();
        idle();
        chk("flush_ready", bus.disp_ready, 1'b1);
        chk("flush_iss_valid", bus.iss_valid, 1'b0);
        step();

        // Random traffic with a small register namespace to force collisions
        for (int c = 0; c < 3000; c++) begin
            idle();
            if ($urandom_range(0, 9) < 6)
                disp($urandom_range(0, 15), ($urandom_range(0, 9) < 3), $urandom_range(0, 15),
                     ($urandom_range(0, 9) < 3), $urandom_range(0, 63), $urandom_range(0, 31));
            if ($urandom_range(0, 1) == 1) cdb(($urandom_range(0, 9) < 8), $urandom_range(0, 15));
            bus.iss_ready = ($urandom_range(0, 9) < 6);
            bus.flush     = ($urandom_range(0, 99) < 2);
            step();
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
